fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), the bubble placed in the IF/ID register.
REQ-003 SHALL provide: clk  in  1  processor clock, rising edge; one clock only.
REQ-004 SHALL provide: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL provide: Select_PC  in  1  branch taken, resolved in Decode.
REQ-006 SHALL provide: dir_salto  in  32  branch target from Decode.
REQ-007 SHALL provide: stall  in  1  hazard hold; freezes PC and IF/ID.
REQ-008 SHALL provide: imem_req  out  1  instruction-memory request.
REQ-009 SHALL provide: imem_addr  out  32  fetch address, equal to PC.
REQ-010 SHALL provide: imem_ready  in  1  memory response valid this cycle (same-cycle, no outstanding transactions).
REQ-011 SHALL provide: imem_rdata  in  32  fetched word, valid when imem_req & imem_ready.
REQ-012 SHALL provide: PCmas4  out  32  registered PC+4 of the instruction in Decode.
REQ-013 SHALL provide: instruccion  out  32  registered instruction to Decode.
REQ-014 SHALL provide: valid_D  out  1  IF/ID holds a real instruction, not a bubble.

Function
REQ-015 SHALL implement FSM states FETCH and HOLD; imem_req = 1 in FETCH, 0 in HOLD.
REQ-016 FETCH, req&ready, stall=0, Select_PC=0: IF/ID <= {PC+4, imem_rdata, valid=1}; PC <= PC+4 (mod 2^32, 0xFFFF_FFFC wraps to 0).
REQ-017 FETCH, req&ready, stall=1: imem_rdata captured in a one-entry buffer; PC and IF/ID unchanged; go to HOLD.
REQ-018 FETCH, ready=0, stall=0: IF/ID <= {PC+4, NOP_INSTR, valid=0}; PC unchanged.
REQ-019 FETCH, ready=0, stall=1: all state unchanged.
REQ-020 HOLD, stall=1: all state unchanged, no request issued.
REQ-021 HOLD, stall=0, Select_PC=0: IF/ID <= {PC+4, buffer, valid=1}; PC <= PC+4; go to FETCH.
REQ-022 Select_PC=1 with stall=0 SHALL take priority in any state: PC <= dir_salto; IF/ID <= bubble (NOP_INSTR, valid=0); buffer discarded; any same-cycle imem response discarded; next state FETCH.
REQ-023 Select_PC=1 with stall=1 SHALL be ignored.
REQ-024 dir_salto with bits[1:0] != 0 SHALL be loaded unmodified; no alignment fault is raised.
REQ-025 imem_addr SHALL change only on a completed fetch, on HOLD exit, or on a redirect.
REQ-026 Latency: a word returned in cycle N with stall=0 SHALL appear on instruccion after the edge ending cycle N.

Reset
REQ-027 reset=0 SHALL asynchronously set PC=RESET_PC, state=FETCH, buffer=0, instruccion=NOP_INSTR, PCmas4=RESET_PC+4, valid_D=0.
REQ-028 Reset asserted mid-stall or mid-HOLD SHALL abandon the buffered word.
REQ-029 After reset release, the first request SHALL issue in the first cycle, with imem_addr=RESET_PC.

Structure
REQ-030 RESET_PC default, NOP_INSTR and the FSM state encoding SHALL be defined in the shared processor package.
REQ-031 The IF/ID register SHALL be a sub-module named if_id_reg, with load, flush and hold controls.

Verification
REQ-032 Reset; imem_ready=1, rdata=0x00500093 -> one cycle later instruccion=0x00500093, PCmas4=4, valid_D=1, imem_addr=4.
REQ-033 ready=0 for 3 cycles at PC=8 -> 3 bubbles (valid_D=0, instruccion=0x13); imem_addr stays 8.
REQ-034 stall=1 in the cycle a word at PC=12 returns, held 2 cycles -> IF/ID frozen, imem_req=0; on release instruccion=that word, PCmas4=16.
REQ-035 Select_PC=1, dir_salto=0x40, stall=0 -> next cycle imem_addr=0x40, valid_D=0; the concurrently fetched word never reaches Decode.
REQ-036 Select_PC=1 with stall=1 -> no redirect; PC and imem_addr unchanged.
REQ-037 reset pulse while in HOLD -> immediate return to reset values; the buffered word is lost.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared processor definitions for the fetch stage: reset PC, bubble encoding
// and the fetch FSM state encoding.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] PC_STEP           = 32'h0000_0004;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, hold freezes, load captures.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic        hold,
  input  logic [31:0] pc4_in,
  input  logic [31:0] instr_in,
  input  logic        valid_in,
  output logic [31:0] pc4,
  output logic [31:0] instr,
  output logic        valid
);

  logic [31:0] pc4_d, pc4_q;
  logic [31:0] instr_d, instr_q;
  logic        valid_d, valid_q;

  // Flush outranks hold, hold outranks load.
  always_comb begin
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      pc4_d   = pc4_in;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (hold) begin
      pc4_d   = pc4_q;
      instr_d = instr_q;
      valid_d = valid_q;
    end else if (load) begin
      pc4_d   = pc4_in;
      instr_d = instr_in;
      valid_d = valid_in;
    end else begin
      pc4_d   = pc4_q;
      instr_d = instr_q;
      valid_d = valid_q;
    end
  end

  // IF/ID storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc4_q   <= next_pc(RESET_PC);
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc4   = pc4_q;
  assign instr = instr_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, FETCH/HOLD request FSM with a one-word buffer
// for responses that arrive while Decode is stalled, and the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Select_PC,
  input  logic [31:0] dir_salto,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCmas4,
  output logic [31:0] instruccion,
  output logic        valid_D
);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic [31:0]  buf_d, buf_q;

  logic         ifid_load_s;
  logic         ifid_flush_s;
  logic [31:0]  ifid_instr_s;
  logic         ifid_valid_s;
  logic [31:0]  pc_plus4_s;

  assign pc_plus4_s = next_pc(pc_q);
  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;

  // Next-state logic; an unstalled redirect beats everything else.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    ifid_load_s  = 1'b0;
    ifid_flush_s = 1'b0;
    ifid_instr_s = NOP_INSTR;
    ifid_valid_s = 1'b0;
    if (Select_PC && !stall) begin
      pc_d         = dir_salto;
      buf_d        = 32'h0000_0000;
      ifid_flush_s = 1'b1;
      state_d      = FETCH;
    end else if (stall) begin
      // Park a word that returns during a stall so the request can drop.
      if ((state_q == FETCH) && imem_ready) begin
        buf_d   = imem_rdata;
        state_d = HOLD;
      end else begin
        buf_d   = buf_q;
        state_d = state_q;
      end
    end else begin
      case (state_q)
        FETCH: begin
          ifid_load_s = 1'b1;
          if (imem_ready) begin
            ifid_instr_s = imem_rdata;
            ifid_valid_s = 1'b1;
            pc_d         = pc_plus4_s;
          end else begin
            ifid_instr_s = NOP_INSTR;
            ifid_valid_s = 1'b0;
            pc_d         = pc_q;
          end
        end
        HOLD: begin
          ifid_load_s  = 1'b1;
          ifid_instr_s = buf_q;
          ifid_valid_s = 1'b1;
          pc_d         = pc_plus4_s;
          buf_d        = 32'h0000_0000;
          state_d      = FETCH;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // PC, FSM state and stall buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  if_id_reg #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (ifid_load_s),
    .flush    (ifid_flush_s),
    .hold     (stall),
    .pc4_in   (pc_plus4_s),
    .instr_in (ifid_instr_s),
    .valid_in (ifid_valid_s),
    .pc4      (PCmas4),
    .instr    (instruccion),
    .valid    (valid_D)
  );

endmodule
